// File: rtl/dma_pkg.sv
// Shared op/type encodings and DMA sequencer state definitions.
// The register file and IO decoder import the same encodings.
package dma_pkg;

  // Data bus operation codes
  localparam logic [1:0] OP_SW  = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  // Data bus target types
  localparam logic [1:0] TYPE_MEM = 2'b00;
  localparam logic [1:0] TYPE_IO  = 2'b11;

  // DMA sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_YIELD = 3'd4,
    ST_FIN   = 3'd5
  } dma_state_t;

  // Read side target: memory when copying mem->IO, IO when copying IO->mem
  function automatic logic [1:0] rd_type(input logic dir);
    return dir ? TYPE_IO : TYPE_MEM;
  endfunction

  // Write side target is always the opposite of the read side
  function automatic logic [1:0] wr_type(input logic dir);
    return dir ? TYPE_MEM : TYPE_IO;
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Address/count bookkeeping for the DMA sequencer: source and destination
// pointers, words remaining and words moved in the current bus tenure.
// Exposes the post-increment values so the FSM can decide and register
// its outputs in the same cycle a write completes.
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int AW = 8,
  parameter int CW = 8,
  parameter int BW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic          burst_clr,
  input  logic [AW-1:0] src_init,
  input  logic [AW-1:0] dst_init,
  input  logic [CW-1:0] count_init,
  output logic [AW-1:0] src,
  output logic [AW-1:0] dst,
  output logic [AW-1:0] src_nxt,
  output logic [CW-1:0] remaining,
  output logic [CW-1:0] rem_nxt,
  output logic [BW-1:0] burst_nxt
);

  logic [BW-1:0] burst;

  // Pointers wrap naturally modulo 2^AW
  assign src_nxt   = src + AW'(1);
  assign rem_nxt   = remaining - CW'(1);
  assign burst_nxt = burst + BW'(1);

  // Load descriptor on start, advance after each completed word
  always_ff @(posedge clk) begin
    if (reset) begin
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      burst     <= '0;
    end else if (load) begin
      src       <= src_init;
      dst       <= dst_init;
      remaining <= count_init;
      burst     <= '0;
    end else begin
      if (burst_clr) begin
        burst <= '0;
      end
      if (step) begin
        src       <= src_nxt;
        dst       <= dst + AW'(1);
        remaining <= rem_nxt;
        burst     <= burst_nxt;
      end
    end
  end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA sequencer. Requests the shared data bus, then runs
// read-word / write-word pairs until the programmed count is exhausted,
// releasing the bus for one cycle after BURST_LEN words or on grant loss.
//
// Bus handshake: while bus_en is high, bus_addr/bus_op/bus_type/bus_wdata
// are held stable until the cycle bus_ack is seen high; that cycle completes
// the access (read data is taken from bus_rdata in that same cycle). Grant
// loss never aborts an access in flight. dbg_state mirrors the FSM state.
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int CW        = 8,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [CW-1:0] count,
  input  logic          dir,
  output logic          bus_req,
  input  logic          bus_grant,
  output logic [AW-1:0] bus_addr,
  output logic [1:0]    bus_op,
  output logic [1:0]    bus_type,
  output logic          bus_en,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] remaining,
  output logic [2:0]    dbg_state
);

  localparam int BW = $clog2(BURST_LEN + 1);

  dma_state_t    state;
  logic          dir_q;
  logic          load;
  logic          step;
  logic          burst_clr;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] src_nxt;
  logic [CW-1:0] rem_nxt;
  logic [BW-1:0] burst_nxt;

  assign dbg_state = state;

  dma_addr_gen #(
    .AW (AW),
    .CW (CW),
    .BW (BW)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .burst_clr  (burst_clr),
    .src_init   (src_addr),
    .dst_init   (dst_addr),
    .count_init (count),
    .src        (src),
    .dst        (dst),
    .src_nxt    (src_nxt),
    .remaining  (remaining),
    .rem_nxt    (rem_nxt),
    .burst_nxt  (burst_nxt)
  );

  // Counter controls: load on accepted start, step on each write ack,
  // fresh burst window whenever the bus is re-requested after a yield
  always_comb begin
    load      = 1'b0;
    step      = 1'b0;
    burst_clr = 1'b0;
    case (state)
      ST_IDLE:  load      = start;
      ST_WR:    step      = bus_ack;
      ST_YIELD: burst_clr = 1'b1;
      default:  ;
    endcase
  end

  // Sequencer FSM with registered bus and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dir_q     <= 1'b0;
      bus_req   <= 1'b0;
      bus_en    <= 1'b0;
      bus_addr  <= '0;
      bus_op    <= 2'b00;
      bus_type  <= 2'b00;
      bus_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus_op <= OP_LW;
          if (start) begin
            dir_q <= dir;
            if (count != '0) begin
              state   <= ST_REQ;
              busy    <= 1'b1;
              bus_req <= 1'b1;
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (bus_grant) begin
            state    <= ST_RD;
            bus_en   <= 1'b1;
            bus_op   <= OP_LW;
            bus_addr <= src;
            bus_type <= rd_type(dir_q);
          end
        end
        ST_RD: begin
          if (bus_ack) begin
            // The write-phase data register is loaded straight from the bus
            state     <= ST_WR;
            bus_op    <= OP_SW;
            bus_addr  <= dst;
            bus_type  <= wr_type(dir_q);
            bus_wdata <= bus_rdata;
          end
        end
        ST_WR: begin
          if (bus_ack) begin
            bus_wdata <= '0;
            if (rem_nxt == '0) begin
              state    <= ST_FIN;
              bus_req  <= 1'b0;
              bus_en   <= 1'b0;
              bus_op   <= OP_LW;
              bus_addr <= '0;
              bus_type <= TYPE_MEM;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if ((burst_nxt == BW'(BURST_LEN)) || !bus_grant) begin
              state    <= ST_YIELD;
              bus_req  <= 1'b0;
              bus_en   <= 1'b0;
              bus_op   <= OP_LW;
              bus_addr <= '0;
              bus_type <= TYPE_MEM;
            end else begin
              state    <= ST_RD;
              bus_op   <= OP_LW;
              bus_addr <= src_nxt;
              bus_type <= rd_type(dir_q);
            end
          end
        end
        ST_YIELD: begin
          state   <= ST_REQ;
          bus_req <= 1'b1;
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
